eth_burst_arbiter: RTL and testbench

- Shares the single Ethernet transmit path between NUM_CH ADC capture FIFOs.
- Selects one ready channel round-robin and drains exactly BURST_LEN words from it, or fewer if that FIFO runs dry.
- Tags the burst with its channel ID and marks the last word.
- Inserts a GAP_LEN-cycle idle gap before the next grant.
- Sits between the per-channel FWFT capture FIFOs and the Ethernet packetiser.

---
 rtl/eth_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/eth_burst_arbiter.sv | 154 +++++++++++++++
 tb/tb_eth_burst_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and helpers for the Ethernet burst arbiter.
//   arb_state_e : one-hot arbiter state (idle, sending a burst, inter-burst gap)
//   id_width()  : bit width needed to index n channels (minimum 1)
package eth_arb_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StSend = 3'b010,
        StGap  = 3'b100
    } arb_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefaultNumCh = 4;
    localparam int unsigned DefaultChW   = id_width(DefaultNumCh);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i         : per-channel request vector
//   rr_ptr_i      : most recently granted channel (lowest priority this round)
//   grant_valid_o : at least one request is set
//   grant_o       : first requesting channel after rr_ptr_i, modulo NUM_CH
module rr_arbiter
    import eth_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic              grant_valid_o,
    output logic [CH_W-1:0]   grant_o
);

    logic [CH_W-1:0] idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_o       = '0;
        idx           = '0;
        // Scan from lowest to highest priority; the last hit is the nearest
        // requester after rr_ptr_i, so it overrides earlier ones.
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(rr_ptr_i) + k) % NUM_CH);
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o       = idx;
            end
        end
    end

endmodule

// File: rtl/eth_burst_arbiter.sv
// Shares one Ethernet transmit path between NUM_CH FWFT capture FIFOs.
// A ready channel (full and not empty) is granted round-robin, up to BURST_LEN
// words are drained from it, and a GAP_LEN-cycle idle gap follows every burst.
//   clk, rstn   : clock, synchronous active-low reset
//   enable      : arbitration enable, only looked at while idle
//   ch_full     : per-channel FIFO full flags
//   ch_empty    : per-channel FIFO empty flags
//   ch_dout     : per-channel FWFT data, channel i at [i*DATA_W +: DATA_W]
//   ch_rd_en    : per-channel pop strobe (one-hot or zero)
//   eth_valid   : eth_data holds a word for the packetiser
//   eth_ready   : packetiser accepts the word
//   eth_data    : data of the granted channel
//   eth_chan    : granted channel ID
//   eth_last    : final word of a full-length burst
//   eth_abort   : one-cycle pulse when a burst is cut short by an empty FIFO
//   busy        : burst or gap in progress
module eth_burst_arbiter
    import eth_arb_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 512,
    parameter int unsigned GAP_LEN   = 2048,
    localparam int unsigned ChW      = id_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_full,
    input  logic [NUM_CH-1:0]        ch_empty,
    input  logic [NUM_CH*DATA_W-1:0] ch_dout,
    output logic [NUM_CH-1:0]        ch_rd_en,
    output logic                     eth_valid,
    input  logic                     eth_ready,
    output logic [DATA_W-1:0]        eth_data,
    output logic [ChW-1:0]           eth_chan,
    output logic                     eth_last,
    output logic                     eth_abort,
    output logic                     busy
);

    localparam int unsigned WordW = $clog2(BURST_LEN);
    localparam int unsigned GapW  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    arb_state_e       state_q, state_d;
    logic [ChW-1:0]   grant_q, grant_d;
    logic [ChW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WordW-1:0] word_cnt_q, word_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;

    logic [NUM_CH-1:0] req;
    logic              arb_valid;
    logic [ChW-1:0]    arb_grant;
    logic              grant_empty;
    logic              word_last;
    logic              xfer;

    assign req         = ch_full & ~ch_empty;
    assign grant_empty = ch_empty[grant_q];
    assign word_last   = (word_cnt_q == WordW'(BURST_LEN - 1));

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (ChW)
    ) u_rr_arbiter (
        .req_i         (req),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (arb_valid),
        .grant_o       (arb_grant)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ch_rd_en   = '0;
        eth_valid  = 1'b0;
        eth_data   = '0;
        eth_chan   = '0;
        eth_last   = 1'b0;
        eth_abort  = 1'b0;
        busy       = 1'b0;
        xfer       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && arb_valid) begin
                    grant_d  = arb_grant;
                    rr_ptr_d = arb_grant;
                    state_d  = StSend;
                end
            end

            StSend: begin
                busy      = 1'b1;
                eth_chan  = grant_q;
                eth_data  = ch_dout[grant_q*DATA_W +: DATA_W];
                eth_valid = ~grant_empty;
                eth_last  = ~grant_empty & word_last;
                xfer      = ~grant_empty & eth_ready;
                if (xfer) begin
                    ch_rd_en = NUM_CH'(1) << grant_q;
                end
                // A dry FIFO ends the burst early, whether or not any word
                // has gone out yet; no eth_last is produced in that case.
                if (grant_empty) begin
                    eth_abort  = 1'b1;
                    word_cnt_d = '0;
                    state_d    = StGap;
                end else if (xfer) begin
                    if (word_last) begin
                        word_cnt_d = '0;
                        state_d    = StGap;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end

            StGap: begin
                busy = 1'b1;
                if (gap_cnt_q == GapW'(GAP_LEN - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= ChW'(NUM_CH - 1);
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_burst_arbiter.sv
// Scoreboard bench for eth_burst_arbiter. Channel FIFOs are modelled as queues
// of random words; a transaction-level model predicts the burst sequence
// (channel order, words, last/abort) and a negedge monitor checks the DUT.
module tb_eth_burst_arbiter;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BURST_LEN = 512;
    localparam int unsigned GAP_LEN   = 2048;
    localparam int unsigned ChW       = 2;
    localparam int unsigned QuietW    = NUM_CH + DATA_W + ChW + 3;

    localparam int unsigned RrSeq [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

    typedef struct {
        bit               abort;
        int unsigned      chan;
        logic [DATA_W-1:0] data;
        bit               last;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     enable;
    logic [NUM_CH-1:0]        ch_full;
    logic [NUM_CH-1:0]        ch_empty;
    logic [NUM_CH*DATA_W-1:0] ch_dout;
    logic [NUM_CH-1:0]        ch_rd_en;
    logic                     eth_valid;
    logic                     eth_ready;
    logic [DATA_W-1:0]        eth_data;
    logic [ChW-1:0]           eth_chan;
    logic                     eth_last;
    logic                     eth_abort;
    logic                     busy;

    always #5 clk = ~clk;

    eth_burst_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .GAP_LEN   (GAP_LEN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .ch_full   (ch_full),
        .ch_empty  (ch_empty),
        .ch_dout   (ch_dout),
        .ch_rd_en  (ch_rd_en),
        .eth_valid (eth_valid),
        .eth_ready (eth_ready),
        .eth_data  (eth_data),
        .eth_chan  (eth_chan),
        .eth_last  (eth_last),
        .eth_abort (eth_abort),
        .busy      (busy)
    );

    // Environment and model state
    logic [DATA_W-1:0] fifo [NUM_CH][$];
    logic [NUM_CH-1:0] full_f;
    exp_t              exp_q [$];
    int unsigned       grant_log [$];
    int unsigned       model_ptr;
    bit                bp_mode;
    int unsigned       cyc;

    // Monitor state
    bit                mon_en;
    logic [NUM_CH-1:0] rd_en_s;
    bit                in_gap;
    bit                in_burst;
    int unsigned       gcnt;
    int unsigned       hs_cnt;
    int unsigned       abort_cnt;
    int unsigned       rd_cnt [NUM_CH];

    int unsigned n_vec;
    int unsigned n_err;

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void refresh();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_full[i]  = full_f[i];
            ch_empty[i] = (fifo[i].size() == 0);
            ch_dout[i*DATA_W +: DATA_W] = (fifo[i].size() == 0) ? '0 : fifo[i][0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_en_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        eth_ready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        refresh();
    endtask

    task automatic fill(input int unsigned ch, input int unsigned n);
        logic [DATA_W-1:0] w;
        for (int j = 0; j < int'(n); j++) begin
            w = DATA_W'($urandom);
            fifo[ch].push_back(w);
        end
        full_f[ch] = 1'b1;
    endtask

    // Spec-level prediction: grant the next full, non-empty channel after the
    // last grant, take min(BURST_LEN, available) words, abort if short.
    task automatic predict();
        int unsigned off [NUM_CH];
        int          pick;
        int unsigned c, avail, n;
        exp_t        e;
        for (int i = 0; i < NUM_CH; i++) off[i] = 0;
        while (1) begin
            pick = -1;
            for (int k = NUM_CH; k >= 1; k--) begin
                c = (model_ptr + k) % NUM_CH;
                if (full_f[c] && fifo[c].size() > off[c]) pick = int'(c);
            end
            if (pick < 0) break;
            c     = pick;
            avail = fifo[c].size() - off[c];
            n     = (avail < BURST_LEN) ? avail : BURST_LEN;
            for (int unsigned j = 0; j < n; j++) begin
                e.abort = 1'b0;
                e.chan  = c;
                e.data  = fifo[c][off[c] + j];
                e.last  = (j == BURST_LEN - 1);
                exp_q.push_back(e);
            end
            if (avail < BURST_LEN) begin
                e.abort = 1'b1;
                e.chan  = c;
                e.data  = '0;
                e.last  = 1'b0;
                exp_q.push_back(e);
            end
            off[c]   += n;
            model_ptr = c;
        end
    endtask

    task automatic wait_drain(input int unsigned limit, input string name);
        int unsigned t = 0;
        while ((exp_q.size() != 0 || busy || in_gap) && t < limit) begin
            tick();
            t++;
        end
        check({name, "_drained"}, (t < limit), 1);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rstn   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
        full_f = '0;
        refresh();
        tick();
        tick();
        rstn = 1'b1;
        exp_q.delete();
        grant_log.delete();
        model_ptr = NUM_CH - 1;
    endtask

    // Monitor: samples away from the active edge and checks against exp_q.
    initial begin : monitor
        exp_t              e;
        logic [QuietW-1:0] quiet;
        forever begin
            @(negedge clk);
            rd_en_s = ch_rd_en;
            if (mon_en) begin
                quiet = {eth_valid, eth_last, eth_abort, ch_rd_en, eth_data, eth_chan};
                for (int i = 0; i < NUM_CH; i++) rd_cnt[i] += ch_rd_en[i];
                if (in_gap) begin
                    if (busy) begin
                        gcnt++;
                        check("gap_quiet", quiet, 0);
                    end else begin
                        check("gap_len", gcnt, GAP_LEN);
                        in_gap = 1'b0;
                    end
                end
                if (!busy) begin
                    check("idle_quiet", quiet, 0);
                end else if (!in_gap) begin
                    check("send_active", eth_valid | eth_abort, 1);
                    if ((eth_valid || eth_abort) && !in_burst) begin
                        grant_log.push_back(eth_chan);
                        in_burst = 1'b1;
                    end
                    if (eth_valid) begin
                        check("queue_has_entry", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q[0];
                            check("word_kind", e.abort, 0);
                            check("chan", eth_chan, e.chan);
                            check("data", eth_data, e.data);
                            check("last", eth_last, e.last);
                            if (eth_ready) begin
                                void'(exp_q.pop_front());
                                hs_cnt++;
                                check("rd_en", ch_rd_en, 1 << e.chan);
                            end else begin
                                check("hold_rd_en", ch_rd_en, 0);
                            end
                        end
                        if (eth_ready && eth_last) begin
                            in_gap   = 1'b1;
                            gcnt     = 0;
                            in_burst = 1'b0;
                        end
                    end
                    if (eth_abort) begin
                        abort_cnt++;
                        check("abort_has_entry", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("abort_kind", e.abort, 1);
                            check("abort_chan", eth_chan, e.chan);
                        end
                        check("abort_quiet", {eth_valid, eth_last, ch_rd_en}, 0);
                        in_gap   = 1'b1;
                        gcnt     = 0;
                        in_burst = 1'b0;
                    end
                end
                if (!rstn) begin
                    in_gap   = 1'b0;
                    in_burst = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned start, t, base;
        rstn      = 1'b0;
        enable    = 1'b0;
        eth_ready = 1'b1;
        bp_mode   = 1'b0;
        full_f    = '0;
        model_ptr = NUM_CH - 1;
        refresh();
        repeat (3) tick();
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_outputs", {eth_valid, eth_last, eth_abort, ch_rd_en, eth_data, eth_chan}, 0);
        mon_en = 1'b1;
        rstn   = 1'b1;

        // Single bursts: ch0 must win first after reset, then ch3.
        fill(0, BURST_LEN);
        fill(3, BURST_LEN);
        refresh();
        enable = 1'b1;
        predict();
        base = rd_cnt[0];
        wait_drain(8000, "single");
        check("single_pops_ch0", rd_cnt[0] - base, BURST_LEN);
        check("single_grants", grant_log.size(), 2);
        check("single_first", grant_log[0], 0);
        check("single_second", grant_log[1], 3);

        // Round-robin with all four requesting; ch1 drops out after one burst.
        do_reset();
        fill(0, 3 * BURST_LEN);
        fill(1, BURST_LEN);
        fill(2, 3 * BURST_LEN);
        fill(3, 2 * BURST_LEN);
        refresh();
        enable = 1'b1;
        predict();
        wait_drain(30000, "rr");
        check("rr_grants", grant_log.size(), 9);
        for (int i = 0; i < 9; i++) check("rr_order", grant_log[i], RrSeq[i]);

        // Backpressure: ready 1,0,0,1 repeating.
        do_reset();
        fill(3, BURST_LEN);
        refresh();
        bp_mode = 1'b1;
        enable  = 1'b1;
        predict();
        base = rd_cnt[3];
        wait_drain(8000, "bp");
        bp_mode = 1'b0;
        check("bp_pops_ch3", rd_cnt[3] - base, BURST_LEN);

        // Truncation: ch2 runs dry after 100 words; ch1 has data but is not full.
        do_reset();
        fill(1, BURST_LEN);
        full_f[1] = 1'b0;
        fill(2, 100);
        fill(3, BURST_LEN);
        refresh();
        enable = 1'b1;
        base   = abort_cnt;
        predict();
        wait_drain(8000, "trunc");
        check("trunc_aborts", abort_cnt - base, 1);
        check("trunc_grants", grant_log.size(), 2);
        check("trunc_first", grant_log[0], 2);
        check("trunc_resume", grant_log[1], 3);
        check("trunc_ch1_untouched", fifo[1].size(), BURST_LEN);

        // Enable dropped at word 200: burst and gap finish, then no new grant.
        do_reset();
        fill(0, 2 * BURST_LEN);
        refresh();
        enable = 1'b1;
        predict();
        start = hs_cnt;
        t     = 0;
        while (hs_cnt < start + 200 && t < 3000) begin
            tick();
            t++;
        end
        check("en_reach_200", (t < 3000), 1);
        enable = 1'b0;
        t      = 0;
        while ((exp_q.size() > BURST_LEN || busy || in_gap) && t < 5000) begin
            tick();
            t++;
        end
        check("en_first_done", (t < 5000), 1);
        repeat (100) tick();
        check("en_no_grant_queue", exp_q.size(), BURST_LEN);
        check("en_no_grant_busy", busy, 0);
        enable = 1'b1;
        tick();
        @(negedge clk);
        check("en_latency_valid", eth_valid, 1);
        check("en_latency_chan", eth_chan, 0);
        wait_drain(8000, "en");

        // Reset mid-burst at word 300 of ch1; ch0 must then win from word 0.
        do_reset();
        fill(1, 600);
        refresh();
        enable = 1'b1;
        predict();
        start = hs_cnt;
        t     = 0;
        while (hs_cnt < start + 300 && t < 3000) begin
            tick();
            t++;
        end
        check("rst_reach_300", (t < 3000), 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_q.delete();
        grant_log.delete();
        model_ptr = NUM_CH - 1;
        fill(0, BURST_LEN);
        refresh();
        predict();
        @(negedge clk);
        check("rst_mid_quiet", {busy, eth_valid, eth_last, eth_abort, ch_rd_en}, 0);
        wait_drain(8000, "rst");
        check("rst_grants", grant_log.size(), 2);
        check("rst_first", grant_log[0], 0);
        check("rst_then", grant_log[1], 1);

        repeat (4) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
